// File: rtl/rom_pkg.sv
// ============================================================================
// Module : rom_pkg
// Brief  : Shared ROM geometry, arbiter FSM state type and SECDED ROM image.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rom_pkg;

    localparam int ROM_ADR_W  = 10;
    localparam int ROM_DATA_W = 32;
    localparam int ROM_CODE_W = 39;   // 1 overall parity + 6 Hamming + 32 data

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Column of the Hamming matrix for data bit j: j-th 6-bit value of weight >= 2.
    function automatic logic [5:0] ecc_col(input int j);
        int         k;
        logic [5:0] col;
        k   = 0;
        col = '0;
        for (int v = 3; v < 64; v++) begin
            if ($countones(6'(v)) >= 2) begin
                if (k == j) col = 6'(v);
                k++;
            end
        end
        return col;
    endfunction

    function automatic logic [5:0] ecc_check(input logic [31:0] d);
        logic [5:0] c;
        c = '0;
        for (int j = 0; j < 32; j++) begin
            if (d[j]) c = c ^ ecc_col(j);
        end
        return c;
    endfunction

    // Stored ROM image; the top word carries a single flipped data bit that
    // the decoder is expected to repair.
    function automatic logic [ROM_CODE_W-1:0] rom_code(input logic [31:0] adr,
                                                        input logic        corrupt);
        logic [31:0]           d;
        logic [5:0]            c;
        logic [ROM_CODE_W-1:0] code;
        d    = (adr * 32'h9E37_79B1) ^ 32'h04A9_339B;
        c    = ecc_check(d);
        code = {^{c, d}, c, d};
        if (corrupt) code[7] = ~code[7];
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom.sv
// ============================================================================
// Module : rom
// Brief  : Combinational SECDED-protected ROM returning corrected data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom
    import rom_pkg::*;
#(
    parameter int ADR_W  = ROM_ADR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic [ADR_W-1:0]  adr,
    input  logic              cs,
    output logic [DATA_W-1:0] d
);

    logic [ROM_CODE_W-1:0] w_code;
    logic [5:0]            w_syn;
    logic [31:0]           w_data;

    // Odd overall parity marks a single-bit error; only then is the syndrome trusted.
    always_comb begin
        w_code = rom_code(32'(adr), &adr);
        w_syn  = w_code[37:32] ^ ecc_check(w_code[31:0]);
        w_data = w_code[31:0];
        if (^w_code) begin
            for (int j = 0; j < 32; j++) begin
                if (w_syn == ecc_col(j)) w_data[j] = ~w_data[j];
            end
        end
        d = cs ? '0 : DATA_W'(w_data);
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin priority select; priority starts one past 'last'.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt
);

    logic [IDX_W-1:0] w_idx;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        gnt   = '0;
        w_idx = '0;
        for (int i = N; i >= 1; i--) begin
            w_idx = IDX_W'((int'(last) + i) % N);
            if (req[w_idx]) gnt = N'(1) << w_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module : rom_arbiter
// Brief  : Round-robin arbiter sharing one ROM port among N_REQ requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_arbiter
    import rom_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADR_W  = ROM_ADR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][ADR_W-1:0] req_adr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADR_W-1:0]            rom_adr,
    output logic                        rom_cs,
    input  logic [DATA_W-1:0]           rom_d,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_last;      // last granted; also the access in flight
    logic [ADR_W-1:0]   r_adr;
    logic [DATA_W-1:0]  r_data;
    logic [N_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_take;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req  (req_valid),
        .last (r_last),
        .gnt  (w_gnt)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_win_idx = IDX_W'(i);
        end
    end

    assign w_take = (r_state == ST_IDLE) && (|req_valid);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|req_valid) w_state_nxt = ST_READ;
            ST_READ: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready[r_last]) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= IDX_W'(N_REQ - 1);
            r_adr   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_last <= w_win_idx;
                r_adr  <= req_adr[w_win_idx];
            end
            if (r_state == ST_READ) r_data <= rom_d;
        end
    end

    // The grant pulse is combinational, so it is masked while reset is held.
    assign req_ready = (w_take && !rst) ? w_gnt : '0;
    assign rsp_valid = (r_state == ST_RESP) ? (N_REQ'(1) << r_last) : '0;
    assign rsp_data  = r_data;
    assign rom_adr   = r_adr;
    assign rom_cs    = (r_state != ST_READ);
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module : tb_rom_arbiter
// Brief  : Scoreboard bench for rom_arbiter with directed ROM read vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0][9:0]  req_adr;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic [9:0]       rom_adr;
    logic             rom_cs;
    logic [31:0]      rom_d;
    logic             busy;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    rom_arbiter #(
        .N_REQ  (2),
        .ADR_W  (10),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_adr   (req_adr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rom_adr   (rom_adr),
        .rom_cs    (rom_cs),
        .rom_d     (rom_d),
        .busy      (busy)
    );

    rom #(
        .ADR_W  (10),
        .DATA_W (32)
    ) u_rom (
        .adr (rom_adr),
        .cs  (rom_cs),
        .d   (rom_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM image: word(a) = a * 0x9E3779B1 ^ 0x04A9339B
    function automatic logic [31:0] exp_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h04A9_339B;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic push(input int idx, input logic [31:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: every completed response handshake is checked against the queue.
    always @(negedge clk) begin
        if (!rst && ((rsp_valid & rsp_ready) != 2'b00)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got valid %b data %h, expected none", rsp_valid, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp", {30'd0, rsp_valid, rsp_data}, {30'd0, 2'b01 << mon_e.idx, mon_e.data});
            end
        end
    end

    task automatic check_reset(input string nm);
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_rsp_data"},  64'(rsp_data),  64'd0);
        chk({nm, "_rom_adr"},   64'(rom_adr),   64'd0);
        chk({nm, "_rom_cs"},    64'(rom_cs),    64'd1);
        chk({nm, "_busy"},      64'(busy),      64'd0);
    endtask

    task automatic wait_grant(input logic [1:0] req, input string nm);
        int n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(req_ready), 64'(req));
    endtask

    task automatic wait_rsp(input logic [1:0] req, input string nm);
        int n = 0;
        @(negedge clk);
        while (rsp_valid == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(rsp_valid), 64'(req));
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int gcyc[4];
        rst       = 1'b1;
        req_valid = 2'b00;
        req_adr   = '0;
        rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read of address 0, exact two-cycle latency, in-flight isolation
        req_valid  = 2'b01;
        req_adr[0] = 10'd0;
        push(0, 32'h04A9_339B);
        wait_grant(2'b01, "single_grant");
        @(posedge clk); #1;
        req_valid  = 2'b00;
        req_adr[0] = 10'h2AA;
        @(negedge clk);
        chk("single_read_phase", {rsp_valid, req_ready, busy, rom_cs, rom_adr},
            {2'b00, 2'b00, 1'b1, 1'b0, 10'd0});
        @(negedge clk);
        chk("single_latency", 64'(rsp_valid), 64'(2'b01));
        @(negedge clk);
        chk("single_idle", {busy, rom_cs, rom_adr}, {1'b0, 1'b1, 10'd0});
        wait_drain("single_drain");

        // Backpressure on requester 1, its rsp_ready low while bit 0 is high
        @(posedge clk); #1;
        rsp_ready  = 2'b01;
        req_valid  = 2'b10;
        req_adr[1] = 10'd3;
        push(1, 32'hDE0F_5E88);
        wait_grant(2'b10, "bp_grant");
        @(posedge clk); #1;
        req_valid  = 2'b01;
        req_adr[0] = 10'd1023;
        push(0, 32'h3B06_79D4);
        wait_rsp(2'b10, "bp_rsp_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {req_ready, rsp_valid, busy, rsp_data, rom_cs},
                {2'b00, 2'b10, 1'b1, 32'hDE0F_5E88, 1'b1});
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", {busy, req_ready}, {1'b0, 2'b01});
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_drain("bp_drain");

        // Reset while a response is pending: aborted, nothing delivered
        @(posedge clk); #1;
        rsp_ready  = 2'b00;
        req_valid  = 2'b01;
        req_adr[0] = 10'd7;
        wait_grant(2'b01, "abort_grant");
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(2'b01, "abort_rsp_valid");
        #2;
        rst = 1'b1;
        #1;
        check_reset("abort");
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight after reset: requester 0 first, then rotation
        rsp_ready  = 2'b11;
        req_valid  = 2'b11;
        req_adr[0] = 10'd5;
        req_adr[1] = 10'd1023;
        push(0, 32'h13BC_53EE);
        push(1, 32'h3B06_79D4);
        push(0, 32'h13BC_53EE);
        push(1, 32'h3B06_79D4);
        for (int g = 0; g < 4; g++) begin
            wait_grant((g % 2 == 0) ? 2'b01 : 2'b10, "cont_grant");
            gcyc[g] = cyc;
            if (g > 0) chk("cont_spacing", 64'(gcyc[g] - gcyc[g-1]), 64'd3);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_drain("cont_drain");

        // Full address sweep from requester 0 at one access per three cycles
        @(posedge clk); #1;
        c0        = 0;
        req_valid = 2'b01;
        for (int a = 0; a < 1024; a++) begin
            req_adr[0] = 10'(a);
            push(0, exp_word(a));
            wait_grant(2'b01, "sweep_grant");
            if (a == 0) c0 = cyc;
            if (a == 1023) chk("sweep_cycles", 64'(cyc - c0), 64'd3069);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        wait_drain("sweep_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, number of requesters (2..4).
REQ-002 The block SHALL have parameter ADR_W, default 10, ROM word-address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, decoded ROM data width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester read request.
REQ-007 req_adr  input  N_REQ x ADR_W  per-requester word address.
REQ-008 req_ready  output  N_REQ  request accepted this cycle (one-hot or zero).
REQ-009 rsp_valid  output  N_REQ  response available to that requester (one-hot or zero).
REQ-010 rsp_ready  input  N_REQ  requester consumes response.
REQ-011 rsp_data  output  DATA_W  response data, shared by all requesters.
REQ-012 rom_adr  output  ADR_W  address to ROM.
REQ-013 rom_cs  output  1  ROM chip select, active-low (0 = selected).
REQ-014 rom_d  input  DATA_W  combinational decoded data from ROM.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, READ, RESP.
REQ-017 IDLE: if any req_valid, grant the round-robin winner, pulse its req_ready for that cycle, latch its index and address, go to READ; else stay in IDLE.
REQ-018 Round-robin: priority starts at the index after the last granted requester, wrapping N_REQ-1 -> 0; after reset the last granted index is N_REQ-1, so requester 0 wins first.
REQ-019 READ (exactly one cycle): rom_cs=0, rom_adr = latched address; rom_d is captured into the rsp_data register at the end of the cycle; go to RESP.
REQ-020 RESP: rsp_valid[granted]=1 and rsp_data stable until rsp_ready[granted]=1, then go to IDLE in the same edge.
REQ-021 rsp_ready on non-granted bits SHALL be ignored.
REQ-022 Latency: req_ready edge to rsp_valid high SHALL be 2 cycles; with rsp_ready held high, back-to-back throughput SHALL be one access per 3 cycles.
REQ-023 rom_cs SHALL be 1 in IDLE and RESP; rom_adr SHALL hold its last value outside READ.
REQ-024 A requester dropping req_valid before grant SHALL NOT be granted; req_valid/req_adr changes after grant SHALL NOT affect the access in flight.
REQ-025 req_ready SHALL be 0 in READ and RESP; simultaneous requests from all N_REQ SHALL be served in rotation, each exactly once per round.
REQ-026 Address ADR_W'(2^ADR_W - 1) SHALL be accessed like any other address, with no wrap or special case.

Reset
REQ-027 On rst high, asynchronously: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rom_adr=0, rom_cs=1, busy=0, last grant=N_REQ-1.
REQ-028 Reset asserted mid-READ or mid-RESP SHALL abort the access with no response delivered; after release the FSM starts from IDLE.

Structure
REQ-029 The shared package rom_pkg SHALL hold ROM_ADR_W=10, ROM_DATA_W=32, ROM_CODE_W=39 and the FSM state enum type.
REQ-030 The round-robin priority logic SHALL be a sub-module rr_arbiter (inputs req, last; output one-hot gnt); the top level instantiates the existing rom and connects it to rom_adr/rom_cs/rom_d.

Verification
REQ-031 Single read: req_valid[0]=1, adr=0 -> req_ready[0] pulse, rsp_valid[0] 2 cycles later, rsp_data = rom.hex[0].
REQ-032 Contention: req_valid=2'b11, adr0=5, adr1=1023, rsp_ready held 1 -> grants in order 0, 1, 0, 1; data = rom.hex[5] and rom.hex[1023] (3b0679d4, including the single-bit-corrupted word in the matrix).
REQ-033 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, busy=1, no req_ready pulse; raising rsp_ready returns to IDLE on the next edge.
REQ-034 Reset mid-RESP: assert rst while rsp_valid=1 -> all outputs reach reset values immediately; a fresh request after release completes normally.
REQ-035 Full sweep: requester 0 reads addresses 0..1023 -> 1024 matches against rom.hex, 0 errors, 3 cycles per access.
